pipe_hazard_fwd_unit: RTL and testbench
=======================================

Name: pipe_hazard_fwd_unit

Overview:
- Parametrised hazard-and-forwarding unit for the 5-stage pipeline (IF/ID/EX/MEM/WB).
- Replaces the separate load-use detector, forwarding selector and post-WB holding register with one block.
- Internally tracks destination tags for EX, MEM, WB and an optional post-WB stage.
- Generates the IF/ID stall, inserts EX bubbles, honours branch flush, and drives the forwarded EX operands.

Parameters:
- DATA_W, 32, operand/result width.
- REG_AW, 5, register address width; register 0 is hardwired zero.
- POST_FWD, 1, 1 = keep a post-WB stage (value+tag) as the lowest-priority forward source; 0 = remove it.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  REG_AW  ID source 1 address.
- id_rt  in  REG_AW  ID source 2 address.
- id_uses_rt  in  1  ID instruction reads rt (R-type, store, branch).
- id_wr_en  in  1  ID instruction writes a register.
- id_rd  in  REG_AW  ID destination (already RegDst-selected).
- id_is_load  in  1  ID instruction is a load.
- flush  in  1  taken branch resolved; squash ID and EX.
- ex_rs_data  in  DATA_W  RF value of rs carried into EX.
- ex_rt_data  in  DATA_W  RF value of rt carried into EX.
- mem_result  in  DATA_W  ALU result in MEM.
- wb_result  in  DATA_W  WB write-back value (after MemtoReg mux).
- stall  out  1  hold PC and IF/ID; bubble EX.
- fwd_rs_sel  out  2  0 RF, 1 MEM, 2 WB, 3 POST.
- fwd_rt_sel  out  2  same encoding.
- ex_rs_val  out  DATA_W  forwarded rs operand for EX.
- ex_rt_val  out  DATA_W  forwarded rt operand for EX.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset:
  - All stage entries invalid; entry = {wr, load, rd, rs, rt}.
  - Post-WB value = 0; stall_cnt = 0.
  - Outputs: stall=0, fwd_*_sel=0, ex_*_val=ex_*_data.
- Each rising edge the tag pipeline shifts: EX<-ID, MEM<-EX, WB<-MEM, POST<-WB.
  - POST also captures wb_result.
  - When POST_FWD=0, the POST logic is absent and sel 3 never occurs.
- Load-use stall (combinational):
  - stall = id_valid & !flush & EX.load & EX.wr & EX.rd!=0 & (EX.rd==id_rs | (id_uses_rt & EX.rd==id_rt)).
  - Exactly one stall cycle per load-use pair; load data is picked up via WB forwarding.
- Bubble: when stall=1 the EX entry loads invalid (wr=0, load=0); MEM/WB/POST still shift.
- Flush:
  - EX entry loads invalid and the ID instruction is dropped.
  - flush forces stall=0; flush and a load-use condition in the same cycle gives no stall.
- Forward select, per operand, evaluated on the EX entry's rs/rt:
  - MEM if MEM.wr & MEM.rd==src & src!=0.
  - Else WB under the same rule.
  - Else POST (only if POST_FWD).
  - Else RF.
  - MEM has the highest priority; a match from a load in MEM is not possible because of the stall.
- Source 0 always selects RF; writes to r0 are never forwarded.
- ex_*_val: pure mux of the selected source, no added latency.
- stall_cnt: increments on each edge where stall=1; holds at all-ones.
- Mid-operation reset: everything clears immediately (asynchronous); the first edge after release shifts in the ID entry normally.

Test Plan:
- Reset: rst_n=0 mid-stream with EX/MEM tags valid -> stall=0, sels=0, stall_cnt=0 immediately; after release, `add r3,r1,r2` issues with no forwarding.
- ALU chain: `add r1,..` followed by `sub r4,r1,r5` -> in sub's EX cycle fwd_rs_sel=1 and ex_rs_val=mem_result (0x0000_0010); next consumer two slots later -> sel=2.
- Load-use: `lw r2,0(r0)` then `add r6,r2,r7` -> stall=1 for exactly one cycle, EX bubble; add then sees fwd_rs_sel=2 with the load data 0xDEAD_BEEF; stall_cnt=1.
- Priority: r1 written by two instructions in MEM and WB simultaneously -> sel=1 (MEM value). With POST_FWD=1 and a consumer three slots behind -> sel=3 holding the captured value.
- r0 and flush: `add r0,..` then a reader of r0 -> sel=0. Load-use pair with flush=1 in the same cycle -> stall=0 and the next EX entry is invalid.
- Counter saturation: CNT_W=4 with 20 consecutive load-use pairs -> stall_cnt stops at 15.

Source files
------------

// File: rtl/pipe_hazard_fwd_unit.sv
// Hazard and forwarding unit for a 5-stage pipeline: load-use stall, EX bubble/flush,
// forwarded EX operands from MEM/WB/optional post-WB, and a saturating stall counter.
module pipe_hazard_fwd_unit #(
   parameter int DATA_W   = 32,
   parameter int REG_AW   = 5,
   parameter int POST_FWD = 1,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rt,
   input  logic              id_wr_en,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_is_load,
   input  logic              flush,
   input  logic [DATA_W-1:0] ex_rs_data,
   input  logic [DATA_W-1:0] ex_rt_data,
   input  logic [DATA_W-1:0] mem_result,
   input  logic [DATA_W-1:0] wb_result,
   output logic              stall,
   output logic [1:0]        fwd_rs_sel,
   output logic [1:0]        fwd_rt_sel,
   output logic [DATA_W-1:0] ex_rs_val,
   output logic [DATA_W-1:0] ex_rt_val,
   output logic [CNT_W-1:0]  stall_cnt
);
   typedef struct packed {
      logic              wr;
      logic              load;
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
   } ex_entry_t;

   // Past EX only the destination tag matters for forwarding.
   typedef struct packed {
      logic              wr;
      logic [REG_AW-1:0] rd;
   } dst_tag_t;

   ex_entry_t         r_ex;
   ex_entry_t         w_id_entry;
   dst_tag_t          r_mem;
   dst_tag_t          r_wb;
   dst_tag_t          w_post;
   logic [DATA_W-1:0] w_post_val;
   logic              w_ex_hit;
   logic              w_stall;
   logic [CNT_W-1:0]  r_stall_cnt;

   assign w_ex_hit = (r_ex.rd == id_rs) || (id_uses_rt && (r_ex.rd == id_rt));
   assign w_stall  = id_valid && !flush && r_ex.load && r_ex.wr && (r_ex.rd != '0) && w_ex_hit;

   // Stalled, flushed or empty ID slots enter EX as an all-zero bubble.
   always_comb begin
      w_id_entry = '0;
      if (id_valid && !flush && !w_stall) begin
         w_id_entry.wr   = id_wr_en;
         w_id_entry.load = id_is_load;
         w_id_entry.rd   = id_rd;
         w_id_entry.rs   = id_rs;
         w_id_entry.rt   = id_rt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex  <= '0;
         r_mem <= '0;
         r_wb  <= '0;
      end else begin
         r_ex  <= w_id_entry;
         r_mem <= '{wr: r_ex.wr, rd: r_ex.rd};
         r_wb  <= r_mem;
      end
   end

   generate
      if (POST_FWD != 0) begin : g_post
         dst_tag_t          r_post;
         logic [DATA_W-1:0] r_post_val;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_post     <= '0;
               r_post_val <= '0;
            end else begin
               r_post     <= r_wb;
               r_post_val <= wb_result;
            end
         end
         assign w_post     = r_post;
         assign w_post_val = r_post_val;
      end else begin : g_no_post
         assign w_post     = '0;
         assign w_post_val = '0;
      end
   endgenerate

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fwd
         logic [REG_AW-1:0] w_src;
         logic [DATA_W-1:0] w_rf;
         logic [1:0]        w_sel;
         logic [DATA_W-1:0] w_val;

         assign w_src = (gi == 0) ? r_ex.rs : r_ex.rt;
         assign w_rf  = (gi == 0) ? ex_rs_data : ex_rt_data;

         // Youngest producer wins; r0 is never forwarded.
         always_comb begin
            w_sel = 2'd0;
            if (w_src != '0) begin
               if (r_mem.wr && (r_mem.rd == w_src))
                  w_sel = 2'd1;
               else if (r_wb.wr && (r_wb.rd == w_src))
                  w_sel = 2'd2;
               else if (w_post.wr && (w_post.rd == w_src))
                  w_sel = 2'd3;
            end
         end

         always_comb begin
            case (w_sel)
               2'd1:    w_val = mem_result;
               2'd2:    w_val = wb_result;
               2'd3:    w_val = w_post_val;
               default: w_val = w_rf;
            endcase
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_stall_cnt <= '0;
      else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
   end

   assign stall      = w_stall;
   assign fwd_rs_sel = g_fwd[0].w_sel;
   assign fwd_rt_sel = g_fwd[1].w_sel;
   assign ex_rs_val  = g_fwd[0].w_val;
   assign ex_rt_val  = g_fwd[1].w_val;
   assign stall_cnt  = r_stall_cnt;
endmodule

// File: tb/tb_pipe_hazard_fwd_unit.sv
// Bench for pipe_hazard_fwd_unit: directed pipeline scenarios plus random traffic, two
// instances (default, and POST_FWD=0 with CNT_W=4) checked against an instruction-history model.
module tb_pipe_hazard_fwd_unit;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid, id_uses_rt, id_wr_en, id_is_load, flush;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [31:0] ex_rs_data, ex_rt_data, mem_result, wb_result;
   logic        stall, stall4;
   logic [1:0]  fwd_rs_sel, fwd_rt_sel, fwd_rs_sel4, fwd_rt_sel4;
   logic [31:0] ex_rs_val, ex_rt_val, ex_rs_val4, ex_rt_val4;
   logic [15:0] stall_cnt;
   logic [3:0]  stall_cnt4;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   pipe_hazard_fwd_unit #(.DATA_W(32), .REG_AW(5), .POST_FWD(1), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .id_wr_en(id_wr_en), .id_rd(id_rd), .id_is_load(id_is_load),
      .flush(flush), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
      .mem_result(mem_result), .wb_result(wb_result), .stall(stall),
      .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .ex_rs_val(ex_rs_val),
      .ex_rt_val(ex_rt_val), .stall_cnt(stall_cnt));

   pipe_hazard_fwd_unit #(.DATA_W(32), .REG_AW(5), .POST_FWD(0), .CNT_W(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .id_wr_en(id_wr_en), .id_rd(id_rd), .id_is_load(id_is_load),
      .flush(flush), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
      .mem_result(mem_result), .wb_result(wb_result), .stall(stall4),
      .fwd_rs_sel(fwd_rs_sel4), .fwd_rt_sel(fwd_rt_sel4), .ex_rs_val(ex_rs_val4),
      .ex_rt_val(ex_rt_val4), .stall_cnt(stall_cnt4));

   // Model: history of instructions that entered EX (newest last) and of wb_result per edge.
   typedef struct packed {
      logic       wr;
      logic       ld;
      logic [4:0] rd;
      logic [4:0] rs;
      logic [4:0] rt;
   } ins_t;

   ins_t        hist[$];
   logic [31:0] wb_hist[$];
   int          m_cnt;

   function automatic ins_t age(int k);
      ins_t e = '0;
      if (hist.size() > k) e = hist[hist.size() - 1 - k];
      return e;
   endfunction

   function automatic logic m_stall();
      ins_t ex = age(0);
      return id_valid && !flush && ex.ld && ex.wr && (ex.rd != 0) &&
             ((ex.rd == id_rs) || (id_uses_rt && (ex.rd == id_rt)));
   endfunction

   // Older instructions at age 1..max_age are MEM, WB, POST in that order.
   function automatic logic [1:0] m_sel(logic [4:0] src, int max_age);
      if (src == 0) return 2'd0;
      for (int k = 1; k <= max_age; k++) begin
         ins_t e = age(k);
         if (e.wr && (e.rd == src)) return 2'(k);
      end
      return 2'd0;
   endfunction

   function automatic logic [31:0] m_val(logic [1:0] s, logic [31:0] rf);
      case (s)
         2'd1:    return mem_result;
         2'd2:    return wb_result;
         2'd3:    return (wb_hist.size() > 0) ? wb_hist[wb_hist.size() - 1] : 32'd0;
         default: return rf;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      ins_t       ex = age(0);
      logic       st = m_stall();
      logic [1:0] sa = m_sel(ex.rs, 3);
      logic [1:0] sb = m_sel(ex.rt, 3);
      logic [1:0] sa4 = m_sel(ex.rs, 2);
      logic [1:0] sb4 = m_sel(ex.rt, 2);
      chk("stall", stall, st);
      chk("stall_p0", stall4, st);
      chk("rs_sel", fwd_rs_sel, sa);
      chk("rt_sel", fwd_rt_sel, sb);
      chk("rs_sel_p0", fwd_rs_sel4, sa4);
      chk("rt_sel_p0", fwd_rt_sel4, sb4);
      chk("rs_val", ex_rs_val, m_val(sa, ex_rs_data));
      chk("rt_val", ex_rt_val, m_val(sb, ex_rt_data));
      chk("rs_val_p0", ex_rs_val4, m_val(sa4, ex_rs_data));
      chk("rt_val_p0", ex_rt_val4, m_val(sb4, ex_rt_data));
      chk("cnt", stall_cnt, (m_cnt > 65535) ? 65535 : m_cnt);
      chk("cnt_p0", stall_cnt4, (m_cnt > 15) ? 15 : m_cnt);
   endtask

   task automatic model_clear();
      hist.delete();
      wb_hist.delete();
      m_cnt = 0;
   endtask

   task automatic rand_data();
      ex_rs_data = $urandom();
      ex_rt_data = $urandom();
      mem_result = $urandom();
      wb_result  = $urandom();
   endtask

   task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urt, input logic wr, input logic [4:0] rd,
                        input logic ld, input logic fl);
      id_valid = v;  id_rs = rs;  id_rt = rt;  id_uses_rt = urt;
      id_wr_en = wr; id_rd = rd;  id_is_load = ld;  flush = fl;
      rand_data();
   endtask

   task automatic settle();
      @(negedge clk);
      check_all();
   endtask

   task automatic step_edge();
      ins_t e;
      logic st;
      @(posedge clk);
      if (!rst_n) begin
         model_clear();
      end else begin
         st = m_stall();
         e  = '0;
         if (id_valid && !flush && !st) begin
            e.wr = id_wr_en; e.ld = id_is_load; e.rd = id_rd; e.rs = id_rs; e.rt = id_rt;
         end
         hist.push_back(e);
         if (hist.size() > 4) void'(hist.pop_front());
         wb_hist.push_back(wb_result);
         if (wb_hist.size() > 1) void'(wb_hist.pop_front());
         if (st) m_cnt++;
      end
      #1;
   endtask

   task automatic cycle();
      settle();
      step_edge();
   endtask

   task automatic nop();
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   // Asynchronous reset asserted away from the clock edge, checked immediately.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_clear();
      check_all();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic hold;
      model_clear();
      rst_n = 1'b0;
      nop();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Reset mid-stream with EX/MEM occupied, then a plain add issues cleanly.
      drive(1, 5'd0, 5'd0, 0, 1, 5'd2, 1, 0); cycle();
      drive(1, 5'd1, 5'd3, 1, 1, 5'd5, 0, 0); cycle();
      do_reset();
      chk("rst_stall", stall, 0);
      chk("rst_rs_sel", fwd_rs_sel, 0);
      chk("rst_cnt", stall_cnt, 0);
      drive(1, 5'd1, 5'd2, 1, 1, 5'd3, 0, 0); cycle();
      nop(); settle();
      chk("post_rst_rs_sel", fwd_rs_sel, 0);
      chk("post_rst_rt_sel", fwd_rt_sel, 0);
      step_edge();

      // Load-use: lw r2,0(r0); add r6,r2,r7
      drive(1, 5'd0, 5'd0, 0, 1, 5'd2, 1, 0); cycle();
      drive(1, 5'd2, 5'd7, 1, 1, 5'd6, 0, 0); settle();
      chk("lu_stall", stall, 1);
      step_edge();
      settle();
      chk("lu_single", stall, 0);
      step_edge();
      nop(); wb_result = 32'hDEAD_BEEF; settle();
      chk("lu_sel", fwd_rs_sel, 2);
      chk("lu_val", ex_rs_val, 32'hDEAD_BEEF);
      chk("lu_cnt", stall_cnt, 1);
      step_edge();

      // ALU chain: add r1; sub r4,r1,r5; or r8,r1,r0
      drive(1, 5'd2, 5'd3, 1, 1, 5'd1, 0, 0); cycle();
      drive(1, 5'd1, 5'd5, 1, 1, 5'd4, 0, 0); cycle();
      drive(1, 5'd1, 5'd0, 1, 1, 5'd8, 0, 0); mem_result = 32'h0000_0010; settle();
      chk("alu_sel", fwd_rs_sel, 1);
      chk("alu_val", ex_rs_val, 32'h0000_0010);
      step_edge();
      nop(); settle();
      chk("alu2_sel", fwd_rs_sel, 2);
      step_edge();

      // Priority: r1 in both MEM and WB -> MEM wins
      drive(1, 5'd2, 5'd3, 1, 1, 5'd1, 0, 0); cycle();
      drive(1, 5'd4, 5'd3, 1, 1, 5'd1, 0, 0); cycle();
      drive(1, 5'd1, 5'd0, 0, 1, 5'd9, 0, 0); cycle();
      nop(); settle();
      chk("pri_sel", fwd_rs_sel, 1);
      chk("pri_val", ex_rs_val, mem_result);
      step_edge();

      // Post-WB: consumer three slots behind the producer
      drive(1, 5'd2, 5'd3, 1, 1, 5'd1, 0, 0); cycle();
      nop(); cycle();
      nop(); cycle();
      drive(1, 5'd1, 5'd0, 0, 1, 5'd9, 0, 0); wb_result = 32'hCAFE_0001; cycle();
      nop(); settle();
      chk("post_sel", fwd_rs_sel, 3);
      chk("post_val", ex_rs_val, 32'hCAFE_0001);
      chk("post_sel_p0", fwd_rs_sel4, 0);
      step_edge();

      // r0 is never forwarded
      drive(1, 5'd2, 5'd3, 1, 1, 5'd0, 0, 0); cycle();
      drive(1, 5'd0, 5'd0, 1, 1, 5'd10, 0, 0); cycle();
      nop(); settle();
      chk("r0_rs_sel", fwd_rs_sel, 0);
      chk("r0_rt_sel", fwd_rt_sel, 0);
      step_edge();

      // Flush on a load-use pair: no stall, flushed add never reaches EX
      drive(1, 5'd0, 5'd0, 0, 1, 5'd2, 1, 0); cycle();
      drive(1, 5'd2, 5'd7, 1, 1, 5'd6, 0, 1); settle();
      chk("flush_stall", stall, 0);
      step_edge();
      drive(1, 5'd6, 5'd6, 1, 0, 5'd0, 0, 0); cycle();
      nop(); settle();
      chk("flush_rs_sel", fwd_rs_sel, 0);
      chk("flush_rt_sel", fwd_rt_sel, 0);
      step_edge();

      // Random traffic; a stalled ID instruction is re-presented
      hold = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (i == 200) do_reset();
         if (!hold)
            drive($urandom_range(0, 99) < 85, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 75,
                  5'($urandom_range(0, 7)), $urandom_range(0, 99) < 30, 1'b0);
         else
            rand_data();
         flush = $urandom_range(0, 99) < 10;
         settle();
         hold = m_stall();
         step_edge();
      end

      // Counter saturation: 20 load-use pairs
      do_reset();
      for (int i = 0; i < 20; i++) begin
         drive(1, 5'd0, 5'd0, 0, 1, 5'd2, 1, 0); cycle();
         drive(1, 5'd2, 5'd7, 1, 1, 5'd6, 0, 0); cycle();
         cycle();
      end
      nop(); settle();
      chk("sat_cnt_p0", stall_cnt4, 15);
      chk("sat_cnt", stall_cnt, 20);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
